// File: rtl/cp0_exception_writer.sv
// ---------------------------------------------------------------------------
// cp0_exception_writer
//
// Builds the CP0 write bus consumed by the ID-stage register file. Exception,
// interrupt and ERET events arriving from the MEM stage are sequenced through
// a small FSM: IDLE -> COMMIT (one cycle of CP0 field writes) -> FLUSH
// (pipeline flush, ending in a one-cycle PC redirect) -> IDLE.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   mem_valid, mem_pc        MEM stage instruction valid / PC
//   mem_in_delay_slot        MEM instruction sits in a branch delay slot
//   ex_valid, ex_code        exception raised by MEM instruction / ExcCode
//   ex_badaddr               faulting address for AdEL/AdES
//   eret                     MEM instruction is ERET
//   int_in                   hardware interrupt lines
//   Status_data, cause_data  current Status / Cause read back from CP0
//   cp0_epc                  current EPC read back from CP0
//   we                       CP0 field write strobes
//                            [0] EXL [1] IM [2] ExcCode [3] BD [4] IP[7:2]
//                            [5] EPC [6] BadVAddr, [31:7] zero
//   interrupt_enable         IM value (passthrough of Status[15:8])
//   Exception_code, EXL      ExcCode / EXL values to write
//   hardware_interruption    registered int_in, written as IP[7:2]
//   software_interruption    IP[1:0] (passthrough of Cause[9:8])
//   epc, BADADDR, Branch_delay  EPC / BadVAddr / Cause.BD values to write
//   flush                    flush IF..MEM
//   redirect_valid/_pc       one-cycle PC redirect strobe and target
// ---------------------------------------------------------------------------
module cp0_exception_writer #(
    parameter logic [31:0] HANDLER_ADDR = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay_slot,
    input  logic        ex_valid,
    input  logic [4:0]  ex_code,
    input  logic [31:0] ex_badaddr,
    input  logic        eret,
    input  logic [5:0]  int_in,
    input  logic [31:0] Status_data,
    input  logic [31:0] cause_data,
    input  logic [31:0] cp0_epc,
    output logic [31:0] we,
    output logic [7:0]  interrupt_enable,
    output logic [4:0]  Exception_code,
    output logic        EXL,
    output logic [5:0]  hardware_interruption,
    output logic [1:0]  software_interruption,
    output logic [31:0] epc,
    output logic [31:0] BADADDR,
    output logic        Branch_delay,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_FLUSH
    } state_t;

    typedef enum logic [1:0] {
        K_INT,
        K_EXC,
        K_ERET
    } kind_t;

    state_t      r_state;
    state_t      w_state_nxt;
    kind_t       r_kind;
    kind_t       w_kind;
    logic [4:0]  r_code;
    logic [31:0] r_pc;
    logic [31:0] r_badaddr;
    logic        r_ds;
    logic        r_oldexl;
    logic [3:0]  r_cnt;
    logic [5:0]  r_ip;
    logic        r_out_en;

    logic        w_pend;
    logic        w_accept;
    logic [4:0]  w_code;
    logic [31:0] w_we;
    logic        w_unused;

    // Only the IE/EXL/IM fields of Status and IP field of Cause matter here.
    assign w_unused = ^{Status_data[31:16], Status_data[7:2],
                        cause_data[31:16], cause_data[7:0]};

    assign w_pend = Status_data[0] & ~Status_data[1] &
                    (|(cause_data[15:8] & Status_data[15:8])) & mem_valid;

    // Event selection: interrupt beats exception beats ERET.
    always_comb begin
        w_accept = 1'b0;
        w_kind   = K_EXC;
        w_code   = ex_code;
        if (w_pend) begin
            w_accept = 1'b1;
            w_kind   = K_INT;
            w_code   = 5'h00;
        end else if (ex_valid) begin
            w_accept = 1'b1;
            w_kind   = K_EXC;
        end else if (eret) begin
            w_accept = 1'b1;
            w_kind   = K_ERET;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_kind    <= K_INT;
            r_code    <= '0;
            r_pc      <= '0;
            r_badaddr <= '0;
            r_ds      <= 1'b0;
            r_oldexl  <= 1'b0;
            r_cnt     <= '0;
            r_ip      <= '0;
            r_out_en  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ip     <= int_in;
            r_out_en <= 1'b1;
            if (r_state == S_IDLE && w_accept) begin
                r_kind    <= w_kind;
                r_code    <= w_code;
                r_pc      <= mem_pc;
                r_badaddr <= ex_badaddr;
                r_ds      <= mem_in_delay_slot;
                r_oldexl  <= Status_data[1];
            end
            if (r_state == S_COMMIT) begin
                r_cnt <= 4'(FLUSH_CYCLES);
            end else if (r_state == S_FLUSH) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_we           = '0;
        Exception_code = '0;
        EXL            = 1'b0;
        epc            = '0;
        BADADDR        = '0;
        Branch_delay   = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // IP is resampled every cycle once out of reset.
        w_we[4] = r_out_en;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                flush       = 1'b1;
                w_state_nxt = S_FLUSH;
                w_we[0]     = 1'b1;
                if (r_kind != K_ERET) begin
                    EXL            = 1'b1;
                    w_we[2]        = 1'b1;
                    Exception_code = r_code;
                    // A nested exception (EXL already set) keeps the
                    // original EPC/BD so the outer handler can still return.
                    if (!r_oldexl) begin
                        w_we[5]      = 1'b1;
                        w_we[3]      = 1'b1;
                        Branch_delay = r_ds;
                        epc          = r_ds ? (r_pc - 32'd4) : r_pc;
                    end
                    if (r_kind == K_EXC && (r_code == 5'h04 || r_code == 5'h05)) begin
                        w_we[6] = 1'b1;
                        BADADDR = r_badaddr;
                    end
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (r_cnt == 4'd1) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = (r_kind == K_ERET) ? cp0_epc : HANDLER_ADDR;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign we                    = w_we;
    assign hardware_interruption = r_ip;
    assign interrupt_enable      = r_out_en ? Status_data[15:8] : '0;
    assign software_interruption = r_out_en ? cause_data[9:8]   : '0;

endmodule

// File: tb/tb_cp0_exception_writer.sv
module tb_cp0_exception_writer;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delay_slot;
    logic        ex_valid;
    logic [4:0]  ex_code;
    logic [31:0] ex_badaddr;
    logic        eret;
    logic [5:0]  int_in;
    logic [31:0] Status_data;
    logic [31:0] cause_data;
    logic [31:0] cp0_epc;
    logic [31:0] we;
    logic [7:0]  interrupt_enable;
    logic [4:0]  Exception_code;
    logic        EXL;
    logic [5:0]  hardware_interruption;
    logic [1:0]  software_interruption;
    logic [31:0] epc;
    logic [31:0] BADADDR;
    logic        Branch_delay;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    cp0_exception_writer #(
        .HANDLER_ADDR(32'hBFC0_0380),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_valid            (mem_valid),
        .mem_pc               (mem_pc),
        .mem_in_delay_slot    (mem_in_delay_slot),
        .ex_valid             (ex_valid),
        .ex_code              (ex_code),
        .ex_badaddr           (ex_badaddr),
        .eret                 (eret),
        .int_in               (int_in),
        .Status_data          (Status_data),
        .cause_data           (cause_data),
        .cp0_epc              (cp0_epc),
        .we                   (we),
        .interrupt_enable     (interrupt_enable),
        .Exception_code       (Exception_code),
        .EXL                  (EXL),
        .hardware_interruption(hardware_interruption),
        .software_interruption(software_interruption),
        .epc                  (epc),
        .BADADDR              (BADADDR),
        .Branch_delay         (Branch_delay),
        .flush                (flush),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        ex_valid          = 1'b0;
        eret              = 1'b0;
        mem_valid         = 1'b0;
        mem_in_delay_slot = 1'b0;
        ex_code           = '0;
        ex_badaddr        = '0;
        mem_pc            = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".we"}, we, 32'h0);
        chk({tag, ".ie"}, {24'h0, interrupt_enable}, 32'h0);
        chk({tag, ".code"}, {27'h0, Exception_code}, 32'h0);
        chk({tag, ".exl"}, {31'h0, EXL}, 32'h0);
        chk({tag, ".hwi"}, {26'h0, hardware_interruption}, 32'h0);
        chk({tag, ".swi"}, {30'h0, software_interruption}, 32'h0);
        chk({tag, ".epc"}, epc, 32'h0);
        chk({tag, ".bad"}, BADADDR, 32'h0);
        chk({tag, ".bd"}, {31'h0, Branch_delay}, 32'h0);
        chk({tag, ".flush"}, {31'h0, flush}, 32'h0);
        chk({tag, ".rv"}, {31'h0, redirect_valid}, 32'h0);
        chk({tag, ".rpc"}, redirect_pc, 32'h0);
    endtask

    typedef struct {
        logic        ex_valid;
        logic        eret;
        logic        mem_valid;
        logic        ds;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] bad;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] cepc;
        logic        accept;
        logic [31:0] e_we;
        logic [4:0]  e_code;
        logic        e_exl;
        logic [31:0] e_epc;
        logic        e_bd;
        logic [31:0] e_bad;
        logic [31:0] e_rpc;
    } vec_t;

    function automatic vec_t mk(
        input logic exv, input logic er, input logic mv, input logic ds,
        input logic [4:0] code, input logic [31:0] pc, input logic [31:0] bad,
        input logic [31:0] st, input logic [31:0] ca, input logic [31:0] cepc,
        input logic acc, input logic [31:0] e_we, input logic [4:0] e_code,
        input logic e_exl, input logic [31:0] e_epc, input logic e_bd,
        input logic [31:0] e_bad, input logic [31:0] e_rpc);
        vec_t v;
        v.ex_valid = exv; v.eret = er; v.mem_valid = mv; v.ds = ds;
        v.code = code; v.pc = pc; v.bad = bad; v.status = st; v.cause = ca;
        v.cepc = cepc; v.accept = acc; v.e_we = e_we; v.e_code = e_code;
        v.e_exl = e_exl; v.e_epc = e_epc; v.e_bd = e_bd; v.e_bad = e_bad;
        v.e_rpc = e_rpc;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        // Ov, no delay slot, EXL=0
        vecs[0] = mk(1,0,1,0, 5'h0C, 32'h8000_0100, 32'h0, 32'h0, 32'h0, 32'h0,
                     1, 32'h3D, 5'h0C, 1, 32'h8000_0100, 0, 32'h0, 32'hBFC0_0380);
        // AdEL in delay slot
        vecs[1] = mk(1,0,1,1, 5'h04, 32'h8000_0204, 32'h3, 32'h0, 32'h0, 32'h0,
                     1, 32'h7D, 5'h04, 1, 32'h8000_0200, 1, 32'h3, 32'hBFC0_0380);
        // interrupt and exception together: interrupt wins with code 00
        vecs[2] = mk(1,0,1,0, 5'h0C, 32'h8000_0300, 32'h0, 32'h401, 32'h400, 32'h0,
                     1, 32'h3D, 5'h00, 1, 32'h8000_0300, 0, 32'h0, 32'hBFC0_0380);
        // interrupt pending but EXL=1: nothing accepted
        vecs[3] = mk(0,0,1,0, 5'h00, 32'h8000_0400, 32'h0, 32'h403, 32'h400, 32'h0,
                     0, 32'h10, 5'h00, 0, 32'h0, 0, 32'h0, 32'h0);
        // Sys with EXL=1: EPC/BD not written
        vecs[4] = mk(1,0,1,0, 5'h08, 32'h8000_0500, 32'h0, 32'h2, 32'h0, 32'h0,
                     1, 32'h15, 5'h08, 1, 32'h0, 0, 32'h0, 32'hBFC0_0380);
        // ERET
        vecs[5] = mk(0,1,1,0, 5'h00, 32'h8000_0600, 32'h0, 32'h2, 32'h0, 32'h8000_0040,
                     1, 32'h11, 5'h00, 0, 32'h0, 0, 32'h0, 32'h8000_0040);
        // RI + ERET together: exception wins; PC 0 in delay slot wraps
        vecs[6] = mk(1,1,1,1, 5'h0A, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 32'h1234_5678,
                     1, 32'h3D, 5'h0A, 1, 32'hFFFF_FFFC, 1, 32'h0, 32'hBFC0_0380);
        // AdES with EXL=1: BadVAddr still written, EPC/BD not
        vecs[7] = mk(1,0,1,1, 5'h05, 32'h8000_0700, 32'hDEAD_BEEF, 32'h2, 32'h0, 32'h0,
                     1, 32'h55, 5'h05, 1, 32'h0, 0, 32'hDEAD_BEEF, 32'hBFC0_0380);

        clear_events();
        rst         = 1'b0;
        int_in      = 6'h3F;
        Status_data = 32'h0000_FF01;
        cause_data  = 32'h0000_0300;
        cp0_epc     = 32'h0;
        ex_valid    = 1'b1;
        ex_code     = 5'h0C;
        mem_valid   = 1'b1;

        // Reset held for two edges with an exception present
        step();
        chk_all_zero("rst1");
        step();
        chk_all_zero("rst2");

        Status_data = 32'h0;
        cause_data  = 32'h0;
        int_in      = 6'h0;
        rst         = 1'b1;
        step();
        chk("rst_release.we", we, 32'h3D);
        chk("rst_release.flush", {31'h0, flush}, 32'h1);
        clear_events();
        step();
        step();
        chk("rst_release.rv", {31'h0, redirect_valid}, 32'h1);
        step();
        chk("rst_release.idle", {31'h0, flush}, 32'h0);

        // Table of single events
        for (int unsigned i = 0; i < 8; i++) begin
            ex_valid          = vecs[i].ex_valid;
            eret              = vecs[i].eret;
            mem_valid         = vecs[i].mem_valid;
            mem_in_delay_slot = vecs[i].ds;
            ex_code           = vecs[i].code;
            mem_pc            = vecs[i].pc;
            ex_badaddr        = vecs[i].bad;
            Status_data       = vecs[i].status;
            cause_data        = vecs[i].cause;
            cp0_epc           = vecs[i].cepc;
            step();
            clear_events();
            chk($sformatf("v%0d.we", i), we, vecs[i].e_we);
            if (vecs[i].accept) begin
                chk($sformatf("v%0d.code", i), {27'h0, Exception_code}, {27'h0, vecs[i].e_code});
                chk($sformatf("v%0d.exl", i), {31'h0, EXL}, {31'h0, vecs[i].e_exl});
                chk($sformatf("v%0d.epc", i), epc, vecs[i].e_epc);
                chk($sformatf("v%0d.bd", i), {31'h0, Branch_delay}, {31'h0, vecs[i].e_bd});
                chk($sformatf("v%0d.bad", i), BADADDR, vecs[i].e_bad);
                chk($sformatf("v%0d.flush_c", i), {31'h0, flush}, 32'h1);
                chk($sformatf("v%0d.rv_c", i), {31'h0, redirect_valid}, 32'h0);
                step();
                chk($sformatf("v%0d.flush_f1", i), {31'h0, flush}, 32'h1);
                chk($sformatf("v%0d.rv_f1", i), {31'h0, redirect_valid}, 32'h0);
                chk($sformatf("v%0d.we_f1", i), we, 32'h10);
                step();
                chk($sformatf("v%0d.flush_f2", i), {31'h0, flush}, 32'h1);
                chk($sformatf("v%0d.rv_f2", i), {31'h0, redirect_valid}, 32'h1);
                chk($sformatf("v%0d.rpc", i), redirect_pc, vecs[i].e_rpc);
                step();
                chk($sformatf("v%0d.flush_i", i), {31'h0, flush}, 32'h0);
                chk($sformatf("v%0d.rv_i", i), {31'h0, redirect_valid}, 32'h0);
            end else begin
                for (int unsigned k = 0; k < 3; k++) begin
                    chk($sformatf("v%0d.noacc_flush%0d", i, k), {31'h0, flush}, 32'h0);
                    step();
                end
            end
        end

        // IP sampling lags int_in by one cycle; IM/IP[1:0] pass through
        Status_data = 32'h0000_A500;
        cause_data  = 32'h0000_0200;
        int_in      = 6'h2A;
        #1;
        chk("ip.before", {26'h0, hardware_interruption}, 32'h0);
        chk("ie.pass", {24'h0, interrupt_enable}, 32'hA5);
        chk("swi.pass", {30'h0, software_interruption}, 32'h2);
        step();
        chk("ip.after", {26'h0, hardware_interruption}, 32'h2A);
        chk("ip.we4", we, 32'h10);
        int_in      = 6'h0;
        Status_data = 32'h0;
        cause_data  = 32'h0;
        step();

        // Reset during COMMIT aborts without further writes
        ex_valid = 1'b1;
        ex_code  = 5'h0C;
        mem_pc   = 32'h8000_0800;
        step();
        clear_events();
        chk("abort.commit_we", we, 32'h3D);
        rst = 1'b0;
        step();
        chk_all_zero("abort");
        rst = 1'b1;
        step();
        chk("abort.idle_flush", {31'h0, flush}, 32'h0);
        chk("abort.idle_we", we, 32'h10);
        step();
        chk("abort.idle_rv", {31'h0, redirect_valid}, 32'h0);

        // Event held continuously: ignored during flush, re-accepted right after IDLE
        ex_valid  = 1'b1;
        ex_code   = 5'h09;
        mem_pc    = 32'h8000_0900;
        step();
        chk("b2b.commit1", we, 32'h3D);
        step();
        chk("b2b.f1_we", we, 32'h10);
        step();
        chk("b2b.f2_rv", {31'h0, redirect_valid}, 32'h1);
        step();
        chk("b2b.idle_flush", {31'h0, flush}, 32'h0);
        step();
        chk("b2b.commit2", we, 32'h3D);
        chk("b2b.code2", {27'h0, Exception_code}, 32'h09);
        clear_events();
        step();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp0_exception_writer.md
Name: cp0_exception_writer

Overview:
- Produces the CP0 write bus that the ID-stage register file consumes: `we`, `interrupt_enable`, `Exception_code`, `EXL`, `hardware_interruption`, `software_interruption`, `epc`, `BADADDR`, `Branch_delay`.
- Takes exception, interrupt and ERET events from the MEM stage. Sequences the CP0 update, pipeline flush and PC redirect through a small FSM.
- Reads back `Status_data` and `cause_data` from the register file.

Parameters:
- HANDLER_ADDR, 32'hBFC0_0380, exception/interrupt vector.
- FLUSH_CYCLES, 2, cycles flush stays high after the commit cycle (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- mem_valid  in  1  MEM stage holds a real instruction
- mem_pc  in  32  PC of MEM instruction
- mem_in_delay_slot  in  1  MEM instruction is in a branch delay slot
- ex_valid  in  1  MEM instruction raised an exception
- ex_code  in  5  ExcCode (AdEL 04, AdES 05, Sys 08, Bp 09, RI 0A, Ov 0C)
- ex_badaddr  in  32  faulting address
- eret  in  1  MEM instruction is ERET
- int_in  in  6  hardware interrupt lines
- Status_data  in  32  current Status (IE bit0, EXL bit1, IM bits15:8)
- cause_data  in  32  current Cause (IP bits15:8)
- cp0_epc  in  32  current EPC value
- we  out  32  CP0 field write strobes (see Behaviour)
- interrupt_enable  out  8  IM value to write
- Exception_code  out  5  ExcCode to write
- EXL  out  1  EXL value to write
- hardware_interruption  out  6  IP[7:2] to write
- software_interruption  out  2  IP[1:0] to write
- epc  out  32  EPC to write
- BADADDR  out  32  BadVAddr to write
- Branch_delay  out  1  Cause.BD to write
- flush  out  1  flush IF..MEM
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target

Behaviour:
- Reset: all outputs 0; state IDLE. Reset is sampled on the clk edge only, when `rst` == 0. Reset mid-sequence aborts to IDLE with no writes.
- `we` bit map:
  - [0] EXL
  - [1] IM
  - [2] ExcCode
  - [3] BD
  - [4] IP[7:2]
  - [5] EPC
  - [6] BadVAddr
  - [31:7] always 0
  - [1] is always 0 in this block.
- `interrupt_enable` = `Status_data[15:8]` and `software_interruption` = `cause_data[9:8]`, passthrough so existing values are preserved.
- IP sampling: `int_in` is registered each cycle into `hardware_interruption`. `we[4]`=1 every cycle out of reset, so IP lags `int_in` by 1 cycle.
- Pending interrupt: `pend` = `Status[0]` & ~`Status[1]` & |(`cause_data[15:8]` & `Status[15:8]`) & `mem_valid`.
- Priority in IDLE: `pend` > `ex_valid` > `eret`. Events are only accepted in IDLE; events in other states are ignored (their instructions are being flushed).
- FSM: IDLE -> COMMIT -> FLUSH -> IDLE.
- IDLE, on an accepted event, latch the following and go to COMMIT:
  - kind: INT, EXC or ERET.
  - code: 00 for INT, else `ex_code`.
  - `mem_pc`, `ex_badaddr`, `mem_in_delay_slot`, and `Status[1]` as `oldexl`.
- COMMIT (exactly 1 cycle): `flush`=1 and write strobes pulse.
  - INT or EXC: `we[0]`=1 with `EXL`=1; `we[2]`=1 with `Exception_code` = code.
  - INT or EXC with `oldexl`=0: also `we[5]`=1 and `we[3]`=1.
    - If the delay slot is set, `epc` = `mem_pc`-4 and `Branch_delay`=1; otherwise `epc` = `mem_pc` and `Branch_delay`=0.
    - Subtraction is modulo 2^32.
  - INT or EXC with `oldexl`=1: EPC and BD are not written.
  - EXC with code 04 or 05: `we[6]`=1, `BADADDR` = latched badaddr. Other codes leave `we[6]`=0.
  - ERET: `we[0]`=1 with `EXL`=0; no other strobes.
  - Counter loads FLUSH_CYCLES.
- FLUSH: `flush`=1; `we[6:0]` = 0 except `we[4]`. Counter decrements each cycle.
  - On the cycle the counter reaches 1: `redirect_valid`=1 and the FSM returns to IDLE next cycle.
  - `redirect_pc` = HANDLER_ADDR for INT/EXC, `cp0_epc` sampled in that cycle for ERET.
- `flush` and `redirect_valid` are 0 in IDLE. A new event may be accepted in the cycle right after the return to IDLE.
- Simultaneous `pend` and `ex_valid`: INT wins, and code 00 is written.
- `ex_valid` and `eret` together: EXC wins.

Test Plan:
- Reset held low 2 cycles while `ex_valid`=1 -> all outputs 0, no `we` pulse; after release, event is accepted on the next edge.
- `ex_valid`=1, `ex_code`=0C, `mem_pc`=0x8000_0100, no delay slot, EXL=0 -> COMMIT cycle: `we`=0x3D, `epc`=0x8000_0100, `Exception_code`=0C, `EXL`=1. Then `flush` is high for 3 cycles total, and `redirect_valid` with `redirect_pc`=0xBFC0_0380 arrives 3 cycles after acceptance.
- `ex_code`=04, `ex_badaddr`=0x0000_0003, `mem_pc`=0x8000_0204, delay slot=1 -> `we`=0x7D, `BADADDR`=0x0000_0003, `epc`=0x8000_0200, `Branch_delay`=1.
- Status=0x0000_0401, `int_in`[0] set with `ex_valid`=1 same cycle -> INT taken, `Exception_code`=00. With Status=0x0000_0403 (EXL=1) -> no event accepted.
- EXC with Status EXL=1 -> `we`=0x15, `epc` unchanged.
- ERET with `cp0_epc`=0x8000_0040 -> `we`=0x11, `EXL`=0, `redirect_pc`=0x8000_0040.
